// File: rtl/ahb_manager.sv
// rtl/ahb_manager.sv - AHB-Lite single-transfer manager for core load/store requests
//
// Purpose: accepts one load/store request at a time from the core memory stage,
// issues a single NONSEQ AHB-Lite transfer, steers byte/halfword lanes and
// returns a one-cycle response. Misaligned or illegal-size requests are
// answered with an error and never reach the bus.
//
// Ports:
//   HCLK, HRESETn         clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write/req_instr   direction, opcode fetch flag
//   req_size/req_addr     access size (00 B, 01 H, 10 W) and byte address
//   req_wdata             right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response
//   HADDR..HWDATA         AHB-Lite manager outputs (all registered)
//   HRDATA/HREADY/HRESP   AHB-Lite subordinate-mux inputs
module ahb_manager #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_instr,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t              state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic [1:0]          htrans_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [3:0]          hprot_q;
  logic [31:0]         hwdata_q;

  logic                misalign_d;
  logic [31:0]         wdata_lanes_d;
  logic [31:0]         rdata_d;
  logic                hresp_err_d;

  always_comb begin
    misalign_d    = 1'b0;
    wdata_lanes_d = req_wdata;
    rdata_d       = HRDATA;
    hresp_err_d   = (HRESP == 2'b01);

    case (req_size)
      2'b00:   misalign_d = 1'b0;
      2'b01:   misalign_d = req_addr[0];
      2'b10:   misalign_d = |req_addr[1:0];
      default: misalign_d = 1'b1;
    endcase

    // Replicate narrow store data so every byte lane carries it; the
    // subordinate picks the lane from HADDR.
    case (req_size)
      2'b00:   wdata_lanes_d = {4{req_wdata[7:0]}};
      2'b01:   wdata_lanes_d = {2{req_wdata[15:0]}};
      default: wdata_lanes_d = req_wdata;
    endcase

    // Lane select uses the address/size latched for the current transfer.
    case (hsize_q[1:0])
      2'b00:   rdata_d = {24'b0, HRDATA[{haddr_q[1:0], 3'b000} +: 8]};
      2'b01:   rdata_d = {16'b0, HRDATA[{haddr_q[1], 4'b0000} +: 16]};
      default: rdata_d = HRDATA;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= TRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hprot_q     <= 4'b0011;
      hwdata_q    <= 32'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (misalign_d) begin
              state_q <= S_FAULT;
            end else begin
              state_q  <= S_ADDR;
              htrans_q <= TRANS_NONSEQ;
              haddr_q  <= req_addr;
              hwrite_q <= req_write;
              hsize_q  <= {1'b0, req_size};
              hprot_q  <= {2'b00, 1'b1, ~req_instr};
              hwdata_q <= wdata_lanes_d;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state_q  <= S_DATA;
            htrans_q <= TRANS_IDLE;
          end
        end
        S_DATA: begin
          // An ERROR with HREADY low is the first half of the two-cycle
          // error response; complete only on its HREADY-high cycle.
          if (HREADY) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= hresp_err_d;
            rsp_rdata_q <= (hresp_err_d || hwrite_q) ? 32'b0 : rdata_d;
          end
        end
        S_FAULT: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= 32'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q & HRESETn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HPROT     = hprot_q;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_manager.sv
// tb/tb_ahb_manager.sv - scoreboard testbench for ahb_manager
module tb_ahb_manager;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_instr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  always #5 HCLK = ~HCLK;

  ahb_manager #(.ADDR_W(32)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_instr (req_instr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response the DUT presents is matched against the queue.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with no response expected at %0t",
                   rsp_rdata, rsp_err, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One bus transfer: aw address-phase and dw data-phase wait states.
  // With err set, the last two data cycles form the ERROR response (dw >= 1).
  task automatic xfer(input logic wr, input logic instr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rd, input logic [31:0] exp_hwdata,
                      input logic [31:0] exp_rdata, input int aw, input int dw,
                      input logic err);
    rsp_t e;
    @(negedge HCLK);
    chk("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_instr = instr;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = err;
    exp_q.push_back(e);
    @(negedge HCLK);
    req_valid = 1'b0;
    for (int i = 0; i <= aw; i++) begin
      if (i > 0) @(negedge HCLK);
      chk("addr_htrans", {30'b0, HTRANS}, 32'h2);
      chk("addr_haddr", HADDR, addr);
      chk("addr_hsize", {29'b0, HSIZE}, {29'b0, 1'b0, size});
      chk("addr_hwrite", {31'b0, HWRITE}, {31'b0, wr});
      chk("addr_hprot", {28'b0, HPROT}, {28'b0, 2'b00, 1'b1, ~instr});
      chk("addr_req_ready", {31'b0, req_ready}, 32'd0);
      chk("addr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      HREADY = (i == aw);
    end
    for (int j = 0; j <= dw; j++) begin
      @(negedge HCLK);
      chk("data_htrans", {30'b0, HTRANS}, 32'h0);
      chk("data_haddr", HADDR, addr);
      chk("data_hsize", {29'b0, HSIZE}, {29'b0, 1'b0, size});
      if (wr) chk("data_hwdata", HWDATA, exp_hwdata);
      chk("data_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      HREADY = (j == dw);
      HRESP  = (err && (j >= dw - 1)) ? 2'b01 : 2'b00;
      HRDATA = (j == dw) ? rd : 32'h0BAD_0BAD;
    end
    @(negedge HCLK);
    chk("rsp_valid_cycle", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_htrans", {30'b0, HTRANS}, 32'h0);
    chk("rsp_req_ready", {31'b0, req_ready}, 32'd0);
    HREADY = 1'b1;
    HRESP  = 2'b00;
    HRDATA = 32'h0;
    @(negedge HCLK);
    chk("post_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic fault(input logic [1:0] size, input logic [31:0] addr);
    rsp_t e;
    @(negedge HCLK);
    chk("flt_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_instr = 1'b0;
    req_size  = size;
    req_addr  = addr;
    req_wdata = 32'h0;
    e.rdata = 32'h0;
    e.err   = 1'b1;
    exp_q.push_back(e);
    @(negedge HCLK);
    req_valid = 1'b0;
    chk("flt_htrans_n1", {30'b0, HTRANS}, 32'h0);
    chk("flt_rsp_valid_n1", {31'b0, rsp_valid}, 32'd0);
    chk("flt_req_ready_n1", {31'b0, req_ready}, 32'd0);
    @(negedge HCLK);
    chk("flt_rsp_valid_n2", {31'b0, rsp_valid}, 32'd1);
    chk("flt_htrans_n2", {30'b0, HTRANS}, 32'h0);
    @(negedge HCLK);
    chk("flt_req_ready_n3", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin : stimulus
    HRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_instr = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    HRDATA    = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 2'b00;

    repeat (3) @(negedge HCLK);
    chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", {31'b0, HWRITE}, 32'd0);
    chk("rst_hsize", {29'b0, HSIZE}, 32'h0);
    chk("rst_hprot", {28'b0, HPROT}, 32'h3);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    HRESETn = 1'b1;

    //   wr    instr size   addr          wdata         HRDATA        exp HWDATA    exp rdata     aw dw err
    xfer(1'b0, 1'b0, 2'b10, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0);
    xfer(1'b1, 1'b0, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0BAD_F00D, 32'hA5A5_A5A5, 32'h0,        0, 0, 1'b0);
    xfer(1'b0, 1'b0, 2'b01, 32'h0000_0012, 32'h0,        32'h1234_5678, 32'h0,        32'h0000_1234, 2, 3, 1'b0);
    xfer(1'b0, 1'b1, 2'b00, 32'h0000_0001, 32'h0,        32'h1122_3344, 32'h0,        32'h0000_0033, 0, 1, 1'b0);
    xfer(1'b1, 1'b0, 2'b01, 32'h0000_0002, 32'h1234_BEEF, 32'h0,        32'hBEEF_BEEF, 32'h0,        1, 0, 1'b0);
    xfer(1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D, 32'h0,        0, 0, 1'b0);
    xfer(1'b0, 1'b0, 2'b00, 32'h0000_0102, 32'h0,        32'hAABB_CCDD, 32'h0,        32'h0000_00BB, 0, 0, 1'b0);
    xfer(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 32'h0,        32'h0,        0, 1, 1'b1);
    xfer(1'b1, 1'b0, 2'b00, 32'h0000_0005, 32'h0000_003C, 32'h0,        32'h3C3C_3C3C, 32'h0,        1, 3, 1'b1);

    fault(2'b10, 32'h0000_0006);
    fault(2'b11, 32'h0000_0006);
    fault(2'b01, 32'h0000_0003);

    // Reset in the middle of a data phase: the transfer must vanish.
    @(negedge HCLK);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0200;
    @(negedge HCLK);
    req_valid = 1'b0;
    HREADY    = 1'b1;
    @(negedge HCLK);
    chk("rstmid_data_htrans", {30'b0, HTRANS}, 32'h0);
    HREADY  = 1'b0;
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk("rstmid_htrans", {30'b0, HTRANS}, 32'h0);
    chk("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstmid_req_ready", {31'b0, req_ready}, 32'd0);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      chk("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    chk("rstmid_req_ready_after", {31'b0, req_ready}, 32'd1);
    xfer(1'b0, 1'b0, 2'b10, 32'h0000_0108, 32'h0, 32'h0123_4567, 32'h0, 32'h0123_4567, 0, 0, 1'b0);

    repeat (3) @(negedge HCLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
